// File: rtl/adder_share_arb.sv
// Two-requester round-robin front end for one shared parallel-prefix adder.
// One issue register stage feeds the prefix tree; results return through per-requester 2-deep FIFOs under credit control.
module adder_share_arb #(
  parameter int LEN_DATA = 32,
  parameter bit RR_INIT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [LEN_DATA-1:0] req0_a,
  input  logic [LEN_DATA-1:0] req0_b,
  input  logic                req0_cin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [LEN_DATA-1:0] req1_a,
  input  logic [LEN_DATA-1:0] req1_b,
  input  logic                req1_cin,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [LEN_DATA-1:0] rsp0_sum,
  output logic                rsp0_cout,
  output logic                rsp0_ovf,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [LEN_DATA-1:0] rsp1_sum,
  output logic                rsp1_cout,
  output logic                rsp1_ovf,
  output logic                busy
);

  localparam int STAGES = $clog2(LEN_DATA);
  localparam int RW     = LEN_DATA + 2;

  // Kogge-Stone prefix adder; cin folded into bit-0 generate. Returns {ovf, cout, sum}.
  function automatic logic [RW-1:0] prefix_add(input logic [LEN_DATA-1:0] a,
                                                input logic [LEN_DATA-1:0] b,
                                                input logic                cin);
    logic [LEN_DATA-1:0] p0, g, pa, gn, pn, s;
    int d;
    p0   = a ^ b;
    g    = a & b;
    g[0] = g[0] | (p0[0] & cin);
    pa   = p0;
    for (int st = 0; st < STAGES; st++) begin
      d  = 1 << st;
      gn = g;
      pn = pa;
      for (int i = d; i < LEN_DATA; i++) begin
        gn[i] = g[i] | (pa[i] & g[i-d]);
        pn[i] = pa[i] & pa[i-d];
      end
      g  = gn;
      pa = pn;
    end
    s = p0 ^ {g[LEN_DATA-2:0], cin};
    return {(a[LEN_DATA-1] == b[LEN_DATA-1]) && (s[LEN_DATA-1] != a[LEN_DATA-1]),
            g[LEN_DATA-1], s};
  endfunction

  logic [1:0]          w_req_vld, w_rsp_rdy, w_elig, w_gnt, w_rsp_vld, w_pop;
  logic [RW-1:0]       w_head [2];
  logic [RW-1:0]       w_res_p1;
  logic                r_rr;
  logic                r_vld_p1, r_tag_p1, r_cin_p1;
  logic [LEN_DATA-1:0] r_a_p1, r_b_p1;

  assign w_req_vld = {req1_valid, req0_valid};
  assign w_rsp_rdy = {rsp1_ready, rsp0_ready};

  always_comb begin
    w_gnt = 2'b00;
    if (!rst) begin
      if (&w_elig) w_gnt = r_rr ? 2'b10 : 2'b01;
      else         w_gnt = w_elig;
    end
  end

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  always_ff @(posedge clk) begin
    if (rst)        r_rr <= RR_INIT;
    else if (|w_gnt) r_rr <= ~w_gnt[1];
  end

  // ---- stage p1: issue register (control reset, data load-on-grant) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_tag_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= |w_gnt;
      if (|w_gnt) r_tag_p1 <= w_gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (|w_gnt) begin
      r_a_p1   <= w_gnt[1] ? req1_a   : req0_a;
      r_b_p1   <= w_gnt[1] ? req1_b   : req0_b;
      r_cin_p1 <= w_gnt[1] ? req1_cin : req0_cin;
    end
  end

  assign w_res_p1 = prefix_add(r_a_p1, r_b_p1, r_cin_p1);

  // ---- stage p2: per-requester response FIFOs and credit counters ----
  for (genvar x = 0; x < 2; x++) begin : g_rsp
    logic [1:0]    r_cnt, r_cred;
    logic          r_wp, r_rp;
    logic [RW-1:0] r_mem [2];
    logic          w_push;

    assign w_push       = r_vld_p1 && (r_tag_p1 == 1'(x));
    assign w_rsp_vld[x] = (r_cnt != 2'd0);
    assign w_pop[x]     = w_rsp_vld[x] && w_rsp_rdy[x];
    assign w_elig[x]    = w_req_vld[x] && (r_cred < 2'd2);
    assign w_head[x]    = w_rsp_vld[x] ? r_mem[r_rp] : '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt  <= 2'd0;
        r_cred <= 2'd0;
        r_wp   <= 1'b0;
        r_rp   <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + 2'(w_push) - 2'(w_pop[x]);
        r_cred <= r_cred + 2'(w_gnt[x]) - 2'(w_pop[x]);
        if (w_push)   r_wp <= ~r_wp;
        if (w_pop[x]) r_rp <= ~r_rp;
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= w_res_p1;
    end
  end

  assign rsp0_valid = w_rsp_vld[0];
  assign rsp1_valid = w_rsp_vld[1];
  assign {rsp0_ovf, rsp0_cout, rsp0_sum} = w_head[0];
  assign {rsp1_ovf, rsp1_cout, rsp1_sum} = w_head[1];
  assign busy = r_vld_p1 | (|w_rsp_vld);

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed scenarios plus a random sweep against a
// transaction-level model (per-requester queues of expected results with accept times).
module tb_adder_share_arb;
  localparam int W   = 32;
  localparam bit RRI = 1'b0;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp0_cout, rsp0_ovf;
  logic         rsp1_valid, rsp1_ready, rsp1_cout, rsp1_ovf;
  logic [W-1:0] rsp0_sum, rsp1_sum;
  logic         busy;

  always #5 clk = ~clk;

  adder_share_arb #(.LEN_DATA(W), .RR_INIT(RRI)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout), .rsp0_ovf(rsp0_ovf),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout), .rsp1_ovf(rsp1_ovf),
    .busy(busy)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           t;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0, n_err = 0, cyc = 0;
  bit   chk_en = 1'b0;
  bit   m_rr = RRI;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t       e;
    logic [W:0] full;
    longint     s, smax, smin;
    full   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    s      = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    smax   = (longint'(1) <<< (W-1)) - 1;
    smin   = -(longint'(1) <<< (W-1));
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (s > smax) || (s < smin);
    e.t    = 0;
    return e;
  endfunction

  function automatic int qsize(input int x);
    return (x == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qhead(input int x);
    return (x == 0) ? q0[0] : q1[0];
  endfunction

  // One clock: check outputs at negedge against the model, then advance the model at posedge.
  task automatic step();
    logic [1:0] elig, gnt, rv, pop;
    exp_t       h, e;
    @(negedge clk);
    elig[0] = req0_valid && (q0.size() < 2) && !rst;
    elig[1] = req1_valid && (q1.size() < 2) && !rst;
    gnt     = (&elig) ? (m_rr ? 2'b10 : 2'b01) : elig;
    for (int x = 0; x < 2; x++) begin
      rv[x] = 1'b0;
      if (qsize(x) > 0) begin
        h     = qhead(x);
        rv[x] = (cyc >= h.t + 2);
      end
    end
    if (chk_en) begin
      chk("req0_ready", req0_ready, gnt[0]);
      chk("req1_ready", req1_ready, gnt[1]);
      chk("rsp0_valid", rsp0_valid, rv[0]);
      chk("rsp1_valid", rsp1_valid, rv[1]);
      chk("busy", busy, (q0.size() + q1.size()) != 0);
      if (rv[0]) begin
        h = qhead(0);
        chk("rsp0_sum", rsp0_sum, h.sum);
        chk("rsp0_cout", rsp0_cout, h.cout);
        chk("rsp0_ovf", rsp0_ovf, h.ovf);
      end
      if (rv[1]) begin
        h = qhead(1);
        chk("rsp1_sum", rsp1_sum, h.sum);
        chk("rsp1_cout", rsp1_cout, h.cout);
        chk("rsp1_ovf", rsp1_ovf, h.ovf);
      end
    end
    pop = rv & {rsp1_ready, rsp0_ready};
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      m_rr = RRI;
    end else begin
      if (pop[0]) void'(q0.pop_front());
      if (pop[1]) void'(q1.pop_front());
      if (gnt[0]) begin e = ref_add(req0_a, req0_b, req0_cin); e.t = cyc; q0.push_back(e); end
      if (gnt[1]) begin e = ref_add(req1_a, req1_b, req1_cin); e.t = cyc; q1.push_back(e); end
      if (|gnt) m_rr = gnt[0];
    end
    cyc++;
    #1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic drive(input int x, input bit v);
    if (x == 0) begin
      req0_valid = v; req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1'($urandom_range(0, 1));
    end else begin
      req1_valid = v; req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int acc0, acc1, pop1;
    rst = 1'b1;
    drive(0, 1'b0); drive(1, 1'b0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    step();
    chk_en = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001; req0_cin = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_rsp0_sum", {rsp0_sum, rsp0_cout, rsp0_ovf}, 0);
    chk("rst_rsp1_sum", {rsp1_sum, rsp1_cout, rsp1_ovf}, 0);

    // Single op: held valid through reset, accepted in the first cycle after.
    rst = 1'b0;
    #1;
    chk("so_accept", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    step();
    chk("so1_valid", rsp0_valid, 1);
    chk("so1_sum", rsp0_sum, 32'h8000_0000);
    chk("so1_cout", rsp0_cout, 0);
    chk("so1_ovf", rsp0_ovf, 1);
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_0001; req0_cin = 1'b0;
    step();
    req0_valid = 1'b0;
    step();
    chk("so2_valid", rsp0_valid, 1);
    chk("so2_sum", rsp0_sum, 32'h0000_0000);
    chk("so2_cout", rsp0_cout, 1);
    chk("so2_ovf", rsp0_ovf, 0);
    repeat (3) step();

    // Contention: grants alternate starting at RR_INIT.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1); drive(1, 1'b1);
      #1;
      if (i < 4) begin
        chk("cont_gnt0", req0_ready, (i % 2) == 0);
        chk("cont_gnt1", req1_ready, (i % 2) == 1);
      end
      step();
    end
    drive(0, 1'b0); drive(1, 1'b0);
    repeat (4) step();

    // Backpressure on requester 1.
    do_reset();
    rsp1_ready = 1'b0;
    acc0 = 0; acc1 = 0; pop1 = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 1'b1); drive(1, 1'b1);
      #1;
      acc0 += int'(req0_valid && req0_ready);
      acc1 += int'(req1_valid && req1_ready);
      step();
    end
    chk("bp_acc1", acc1, 2);
    chk("bp_rdy1", req1_ready, 0);
    chk("bp_req0_flows", acc0 >= 6, 1);
    rsp1_ready = 1'b1;
    acc1 = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1); drive(1, 1'b1);
      #1;
      acc1 += int'(req1_valid && req1_ready);
      pop1 += int'(rsp1_valid && rsp1_ready);
      step();
    end
    chk("bp_pops", pop1 >= 2, 1);
    chk("bp_resume", acc1 > 0, 1);
    drive(0, 1'b0); drive(1, 1'b0);
    repeat (4) step();

    // Simultaneous push/pop on FIFO0: head advances in order.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_cin = 1'b0;
    step();
    req0_a = 32'd10; req0_b = 32'd20; req0_cin = 1'b1;
    step();
    req0_valid = 1'b0;
    chk("pp_head_a_vld", rsp0_valid, 1);
    chk("pp_head_a", rsp0_sum, 32'd3);
    step();
    chk("pp_head_b_vld", rsp0_valid, 1);
    chk("pp_head_b", rsp0_sum, 32'd31);
    repeat (3) step();

    // Mid-flight reset discards both in-flight ops.
    do_reset();
    drive(0, 1'b1); drive(1, 1'b1);
    step();
    drive(0, 1'b1); drive(1, 1'b1);
    step();
    drive(0, 1'b0); drive(1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mr_rsp0", rsp0_valid, 0);
      chk("mr_rsp1", rsp1_valid, 0);
      chk("mr_busy", busy, 0);
      step();
    end
    drive(0, 1'b1); drive(1, 1'b1);
    #1;
    chk("mr_rr0", req0_ready, !RRI);
    chk("mr_rr1", req1_ready, RRI);
    step();
    drive(0, 1'b0); drive(1, 1'b0);
    repeat (4) step();

    // Random sweep.
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      drive(0, $urandom_range(0, 9) < 7);
      drive(1, $urandom_range(0, 9) < 7);
      rsp0_ready = ($urandom_range(0, 9) < 6);
      rsp1_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    drive(0, 1'b0); drive(1, 1'b0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (6) step();
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
